// File: rtl/fpu_pkg.sv
// fpu_pkg: custom-float field layout, adder status codes and scheduler state encoding.
package fpu_pkg;
  localparam int SIGN_BIT = 31;
  localparam int EXP_W = 6;
  localparam int MANT_W = 25;
  localparam int BIAS = 31;
  localparam logic [3:0] ST_EXACT = 4'b0001;
  localparam logic [3:0] ST_OVF = 4'b0011;
  localparam logic [3:0] ST_UNF = 4'b0111;
  localparam logic [3:0] ST_INEXACT = 4'b1111;
  localparam logic [3:0] ST_TIMEOUT = 4'b1000;
  typedef enum logic [1:0] {IDLE, LOAD, WAIT, RESP} sched_state_t;
endpackage

// File: rtl/fpu_sched_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first set request at or above ptr, wrapping.
module rr_arbiter #(
  parameter int NREQ = 4,
  localparam int IW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  input  logic            enable,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   id
);
  // Walk offsets from farthest to nearest so the closest requester overwrites the rest.
  always_comb begin
    grant = '0;
    id = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (enable && req[(int'(ptr) + k) % NREQ]) begin
        grant = NREQ'(1) << ((int'(ptr) + k) % NREQ);
        id = IW'((int'(ptr) + k) % NREQ);
      end
    end
  end
endmodule

// File: rtl/fpu_sched.sv
// fpu_sched: round-robin sharing of one custom-float adder between NREQ requesters.
// Define FPU_SCHED_TIMEOUT_EN to add a WAIT watchdog that returns status 1000 after TIMEOUT cycles.
module fpu_sched
  import fpu_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int TIMEOUT = 64
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*32-1:0] req_op_a,
  input  logic [NREQ*32-1:0] req_op_b,
  output logic [NREQ-1:0]    rsp_valid,
  input  logic [NREQ-1:0]    rsp_ready,
  output logic [31:0]        rsp_data,
  output logic [3:0]         rsp_status,
  output logic [31:0]        fpu_op_a,
  output logic [31:0]        fpu_op_b,
  output logic               fpu_rst_n,
  input  logic [31:0]        fpu_data,
  input  logic [3:0]         fpu_status,
  output logic               busy
);
  localparam int IW = $clog2(NREQ);
  if (NREQ < 2 || NREQ > 8 || TIMEOUT < 1) begin : g_bad_cfg
    $error("fpu_sched: unsupported NREQ or TIMEOUT");
  end
  sched_state_t state, state_n;
  logic [IW-1:0] ptr, id, win_id;
  logic [NREQ-1:0] grant;
  logic clear_n, accept, hit, expired, done;
  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req(req_valid),
    .ptr(ptr),
    .enable(state == IDLE),
    .grant(grant),
    .id(win_id)
  );
  assign hit = fpu_status != '0;
`ifdef FPU_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] wait_cnt;
  always_ff @(posedge clock or negedge reset)
    if (!reset) wait_cnt <= '0;
    else wait_cnt <= (state == WAIT) ? wait_cnt + 1'b1 : '0;
  assign expired = wait_cnt == TW'(TIMEOUT - 1);
`else
  assign expired = 1'b0;
`endif
  assign done = hit || expired;
  // The adder restarts only while clear_n is low, i.e. during the single LOAD cycle.
  assign fpu_rst_n = reset & clear_n;
  always_ff @(posedge clock or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_n;
  always_comb begin
    req_ready = grant;
    accept = |grant;
    busy = state != IDLE;
    state_n = (state == IDLE) ? (accept ? LOAD : IDLE)
            : (state == LOAD) ? WAIT
            : (state == WAIT) ? (done ? RESP : WAIT)
            : (rsp_ready[id] ? IDLE : RESP);
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      ptr <= '0;
      id <= '0;
      clear_n <= 1'b1;
      fpu_op_a <= '0;
      fpu_op_b <= '0;
      rsp_valid <= '0;
      rsp_data <= '0;
      rsp_status <= '0;
    end else begin
      clear_n <= !accept;
      if (accept) begin
        fpu_op_a <= req_op_a[32*win_id +: 32];
        fpu_op_b <= req_op_b[32*win_id +: 32];
        id <= win_id;
        ptr <= (win_id == IW'(NREQ - 1)) ? '0 : win_id + 1'b1;
      end
      if (state == WAIT && done) begin
        rsp_valid <= NREQ'(1) << id;
        rsp_data <= hit ? fpu_data : '0;
        rsp_status <= hit ? fpu_status : ST_TIMEOUT;
      end else if (state == RESP && rsp_ready[id]) begin
        rsp_valid <= '0;
      end
    end
endmodule

// File: doc/fpu_sched.md
# fpu_sched

Round-robin scheduler that shares one instance of the team's 32-bit custom-float adder (sign[31], exp[30:25] bias 31, mant[24:0]) between NREQ requesters. It accepts one operand pair at a time over a valid/ready handshake, holds the operands stable, restarts the adder's internal sequence, and detects completion. It then returns the adder's data and status to the originating requester over a per-requester response handshake. It sits between the adder and the client blocks, and is the only driver of the adder's operand and reset inputs.

## Interface
- NREQ, 4: number of requesters, 2..8.
- TIMEOUT, 64: watchdog limit in cycles. Used only with FPU_SCHED_TIMEOUT_EN.
- clock  in  1  clock, rising edge.
- reset  in  1  reset, asynchronous, active-low.
- req_valid  in  NREQ  requester i has an operand pair.
- req_ready  out  NREQ  one-hot grant/accept. Reset value 0.
- req_op_a  in  NREQ*32  operand A, slice i = [32*i+31:32*i].
- req_op_b  in  NREQ*32  operand B, same slicing.
- rsp_valid  out  NREQ  one-hot result valid. Reset value 0.
- rsp_ready  in  NREQ  requester i accepts its result.
- rsp_data  out  32  result, shared by all requesters. Reset value 0.
- rsp_status  out  4  status, shared. Reset value 0.
- fpu_op_a, fpu_op_b  out  32 each  adder operands. Reset value 0.
- fpu_rst_n  out  1  adder reset = reset AND registered clear_n. Low during reset.
- fpu_data  in  32  adder data output.
- fpu_status  in  4  adder status output. 0 while the adder is in reset. Completion codes: 0001 exact, 0011 overflow, 0111 underflow, 1111 inexact.
- busy  out  1  high in any state other than IDLE. Reset value 0.

## Operation
- FSM states: IDLE, LOAD, WAIT, RESP. Reset state is IDLE, with the pointer at 0 and clear_n = 1.
- IDLE:
  - The arbiter picks the first requester with req_valid set, searching from ptr upward and wrapping.
  - req_ready of the winner is driven combinationally in the same cycle.
  - When valid and ready are both high, the block captures the operands into fpu_op_a/b, stores the id, sets clear_n = 0, and moves to LOAD.
  - ptr becomes id+1 mod NREQ.
- LOAD:
  - fpu_rst_n is low for exactly this one cycle, which restarts the adder at its first state with status 0.
  - The block sets clear_n = 1 and moves to WAIT.
- WAIT:
  - The block moves when fpu_status != 0, sampled on any cycle after LOAD.
  - At that point it registers fpu_data into rsp_data and fpu_status into rsp_status, sets rsp_valid[id], and moves to RESP.
- RESP:
  - Outputs are held stable until rsp_ready[id] is high.
  - On that handshake the block clears rsp_valid and returns to IDLE.
  - rsp_ready on other bits is ignored.
- fpu_op_a/b stay constant from LOAD until the next capture.
- req_ready is 0 in every state except IDLE, so at most one operation is outstanding.
- A requester that drops req_valid before its grant loses its place and gets no result.
- Reset mid-operation (any state) returns the block to IDLE. Any pending result is discarded, with no rsp_valid.
- The block does not modify data or status: it returns the adder's value bit-exact.

## Timing
- Grant to LOAD takes 1 cycle. LOAD lasts 1 cycle.
- WAIT lasts as long as the adder's sequence: 2 pre-sum cycles, 1 sum cycle, 1..27 normalise cycles, and 1 final cycle. Minimum 5 cycles, maximum 31.
- rsp_valid is registered and rises the cycle after fpu_status first becomes nonzero.
- Minimum request-to-response handshake is 8 cycles when rsp_ready is held high.
- A back-to-back grant is possible in the cycle after the RESP handshake. Each request/response cycle uses one IDLE cycle.
- Fairness: after requester i is served, every other valid requester is served before i again.

## Configuration
- FPU_SCHED_TIMEOUT_EN:
  - Defined: a WAIT cycle counter runs. If the count reaches TIMEOUT without nonzero status, the block moves to RESP with rsp_data = 0 and rsp_status = 4'b1000 (timeout).
  - Undefined: there is no counter, and WAIT waits indefinitely.

## Structure
- Package fpu_pkg holds:
  - field widths (SIGN_BIT = 31, EXP_W = 6, MANT_W = 25) and BIAS = 31;
  - status constants ST_EXACT, ST_OVF, ST_UNF, ST_INEXACT, ST_TIMEOUT;
  - the sched_state_t enum.
- Sub-module rr_arbiter (NREQ):
  - inputs: req vector, ptr, enable;
  - outputs: one-hot grant and encoded id.
  - It is purely combinational. ptr is owned by fpu_sched.

## Test plan
- Single request: requester 0 sends A = 0x3E000000 (1.0) and B = 0x3E000000, with rsp_ready held high. Required: a one-cycle fpu_rst_n low pulse, then rsp_valid[0] with rsp_data 0x40000000 and status 0001.
- Round-robin: requesters 0, 1 and 3 all hold valid. Required: grants in order 0, 1, 3, 0. Each result goes only to its own rsp_valid bit.
- Response backpressure: rsp_ready[2] is held low for 20 cycles. Required: rsp_data and rsp_status stay stable, req_ready stays 0, and the next grant follows the handshake.
- Cancellation: req_valid[1] is dropped while requester 0 is being served. Required: requester 1 is never granted and no rsp_valid[1] appears.
- Reset mid-WAIT: reset is asserted while in WAIT. Required: all outputs go to 0 and busy = 0. The first operation after release completes normally.
- Timeout (macro defined, TIMEOUT = 8): the bench holds fpu_status = 0. Required: after 8 WAIT cycles, rsp_status = 1000 and rsp_data = 0. With the macro undefined, the block stays in WAIT.
